// File: rtl/fp32_uart_rx_if.sv
// Word hand-off from the FP32 UART receiver to downstream FP logic, plus its error strobes.
interface fp32_uart_rx_if;
  logic [31:0] word_o;
  logic        word_valid_o;
  logic        word_ready_i;
  logic        frame_err_o;
  logic        overrun_err_o;

  modport master (
    output word_o, word_valid_o, frame_err_o, overrun_err_o,
    input  word_ready_i
  );

  modport slave (
    input  word_o, word_valid_o, frame_err_o, overrun_err_o,
    output word_ready_i
  );
endinterface

// File: rtl/fp32_uart_rx.sv
// 8N1 UART receiver that gathers four bytes (LSB byte first) into one FP32 word
// and offers it over valid/ready; a stalled partial word is dropped after an idle timeout.
//
//  state   | meaning
//  IDLE    | line idle, waiting for a falling edge
//  START   | half a bit in, confirming the start bit
//  DATA    | sampling 8 data bits at mid-bit
//  STOP    | sampling the stop bit
//  DONE    | byte good, written to its slot
//  BREAK   | framing error, waiting for the line to return high
module fp32_uart_rx #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD_RATE    = 115_200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           uart_rx_i,
  fp32_uart_rx_if.master bus
);
  localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int CNT_W     = $clog2(CLKS_PER_BIT + 1);
  localparam int TO_W      = $clog2(TO_CYCLES + 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [TO_W-1:0]  TO_M1   = TO_W'(TO_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_DONE, S_BREAK
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             frame_err_d, byte_done;

  logic             sync1_q, rx_s;
  logic [1:0]       idx_q;
  logic [3:0][7:0]  slot_q;
  logic             word_done_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic             to_expire;

  logic [31:0]      word_q;
  logic             valid_q, frame_err_q, overrun_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync1_q <= uart_rx_i;
      rx_s    <= sync1_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    byte_done   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          cnt_d   = HALF_M1;
          bit_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          if (rx_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            cnt_d   = FULL_M1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = FULL_M1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == '0) begin
          if (rx_s) begin
            state_d = S_DONE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        byte_done = 1'b1;
        state_d   = S_IDLE;
      end
      S_BREAK: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Timeout only runs while a partial word sits idle; leaving IDLE reloads it.
  assign to_expire = (state_q == S_IDLE) && (idx_q != 2'd0) && (to_cnt_q == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q       <= '0;
      slot_q      <= '0;
      word_done_q <= 1'b0;
      to_cnt_q    <= TO_M1;
    end else begin
      word_done_q <= byte_done && (idx_q == 2'd3);
      if (byte_done) slot_q[idx_q] <= shift_q;
      if (frame_err_d || to_expire) idx_q <= '0;
      else if (byte_done)           idx_q <= idx_q + 2'd1;
      if (state_q != S_IDLE || idx_q == 2'd0) to_cnt_q <= TO_M1;
      else if (to_cnt_q != '0)                to_cnt_q <= to_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
      overrun_q   <= word_done_q && valid_q && !bus.word_ready_i;
      if (word_done_q && (!valid_q || bus.word_ready_i)) begin
        word_q  <= slot_q;
        valid_q <= 1'b1;
      end else if (valid_q && bus.word_ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.word_o        = word_q;
  assign bus.word_valid_o  = valid_q;
  assign bus.frame_err_o   = frame_err_q;
  assign bus.overrun_err_o = overrun_q;
endmodule
